// File: rtl/demux4_buffer.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ack buffer per output lane.
// Optional DEMUX4_AUTO_ROTATE_EN: an internal round-robin pointer replaces control as the lane select.

module demux4_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic             full,
    output logic             empty
);

    // Handshakes: a producer word moves when in_valid & in_ready are both high at a rising
    // edge; lane i's word is consumed when out_valid[i] & out_ack[i] are both high at an edge.
    // in_ready never depends on in_valid, and a lane being acked may be refilled in that cycle.

    logic [1:0]       sel;
    logic             accept;
    logic [3:0]       valid_q;
    logic [WIDTH-1:0] data_q [4];

`ifdef DEMUX4_AUTO_ROTATE_EN
    logic [1:0] ptr_q;
    logic       unused_control;

    assign unused_control = ^control;
    assign sel            = ptr_q;

    // The pointer only advances on an accepted word, so a stalled producer keeps its lane.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else if (accept) begin
            ptr_q <= ptr_q + 2'd1;
        end
    end
`else
    assign sel = control;
`endif

    assign in_ready = ~valid_q[sel] | out_ack[sel];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (sel == 2'(i))) begin
                    data_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                end else if (out_ack[i]) begin
                    // Acking an empty lane just rewrites a zero.
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign out_valid = valid_q;
    assign full      = &valid_q;
    assign empty     = ~|valid_q;

endmodule

// File: tb/tb_demux4_buffer.sv
// Self-checking bench for demux4_buffer: directed scenarios plus randomized traffic,
// all checked against a lane-array reference model kept in this file.

module tb_demux4_buffer;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   control;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ack;
    logic         full;
    logic         empty;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: four lanes, each a flag plus a word, and a round-robin index.
    bit           m_valid [4];
    logic [W-1:0] m_data  [4];
    int           m_ptr;

    logic rdy_act;
    logic rdy_exp;

    demux4_buffer #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .full      (full),
        .empty     (empty)
    );

    always #5 clock = ~clock;

    function automatic int model_sel(input logic [1:0] ctl);
`ifdef DEMUX4_AUTO_ROTATE_EN
        return m_ptr;
`else
        return int'(ctl);
`endif
    endfunction

    function automatic logic [3:0] model_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [W-1:0] dut_lane(input int i);
        case (i)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    // Applies one cycle of inputs, records in_ready against the model, then advances the model.
    task automatic drive_cycle(input logic rst, input logic iv, input logic [W-1:0] d,
                               input logic [1:0] ctl, input logic [3:0] ack);
        int s;
        bit take;
        reset    = rst;
        in_valid = iv;
        in_data  = d;
        control  = ctl;
        out_ack  = ack;
        #1;
        rdy_act = in_ready;
        s       = model_sel(ctl);
        rdy_exp = !m_valid[s] || ack[s];
        take    = iv && rdy_exp;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] = 0;
                m_data[i]  = '0;
            end
            m_ptr = 0;
        end else begin
            for (int i = 0; i < 4; i++) if (ack[i]) m_valid[i] = 0;
            if (take) begin
                m_valid[s] = 1;
                m_data[s]  = d;
                m_ptr      = (m_ptr + 1) % 4;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b1, 8'hFF, 2'd3, 4'hF);
        drive_cycle(1'b1, 1'b0, 8'h00, 2'd0, 4'h0);
        drive_cycle(1'b0, 1'b0, 8'h00, 2'd0, 4'h0);
        vectors++;
        if (rdy_act !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", rdy_act);
        end
        vectors++;
        if (out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0000", out_valid);
        end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got empty=%b full=%b want empty=1 full=0", empty, full);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut_lane(i) !== '0) begin
                miscompares++;
                $display("FAIL reset_data%0d: got %h want 00", i, dut_lane(i));
            end
        end
    endtask

    task automatic test_single_lane();
        drive_cycle(1'b0, 1'b1, 8'hA5, 2'd2, 4'h0);
        vectors++;
        if (rdy_act !== rdy_exp) begin
            miscompares++;
            $display("FAIL single_in_ready: got %b want %b", rdy_act, rdy_exp);
        end
        vectors++;
        if (out_valid !== model_vec()) begin
            miscompares++;
            $display("FAIL single_out_valid: got %b want %b", out_valid, model_vec());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut_lane(i) !== m_data[i]) begin
                miscompares++;
                $display("FAIL single_data%0d: got %h want %h", i, dut_lane(i), m_data[i]);
            end
        end
    endtask

    task automatic test_full_passthrough();
        logic [W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_cycle(1'b1, 1'b0, 8'h00, 2'd0, 4'h0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, words[i], 2'(i), 4'h0);
        vectors++;
        if (full !== 1'b1 || empty !== 1'b0 || out_valid !== model_vec()) begin
            miscompares++;
            $display("FAIL fill_full: got full=%b empty=%b valid=%b want full=1 empty=0 valid=%b",
                     full, empty, out_valid, model_vec());
        end
        // Stall: target lane occupied and not acked.
        drive_cycle(1'b0, 1'b1, 8'h55, 2'd1, 4'h0);
        vectors++;
        if (rdy_act !== 1'b0 || rdy_exp !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_in_ready: got %b want 0", rdy_act);
        end
        vectors++;
        if (out_valid !== 4'hF || out_data1 !== m_data[1]) begin
            miscompares++;
            $display("FAIL stall_hold: got valid=%b data1=%h want valid=1111 data1=%h",
                     out_valid, out_data1, m_data[1]);
        end
        // Pass-through: the held word goes in as the lane is acked.
        drive_cycle(1'b0, 1'b1, 8'h55, 2'd1, 4'b0011);
        vectors++;
        if (rdy_act !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_in_ready: got %b want 1", rdy_act);
        end
        vectors++;
        if (out_valid !== model_vec()) begin
            miscompares++;
            $display("FAIL pass_out_valid: got %b want %b", out_valid, model_vec());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut_lane(i) !== m_data[i]) begin
                miscompares++;
                $display("FAIL pass_data%0d: got %h want %h", i, dut_lane(i), m_data[i]);
            end
        end
    endtask

    task automatic test_ack_all();
        drive_cycle(1'b1, 1'b0, 8'h00, 2'd0, 4'h0);
        drive_cycle(1'b0, 1'b1, 8'h6C, 2'd0, 4'h0);
        drive_cycle(1'b0, 1'b1, 8'h9D, 2'd3, 4'h0);
        vectors++;
        if (out_valid !== model_vec()) begin
            miscompares++;
            $display("FAIL ack_prep_valid: got %b want %b", out_valid, model_vec());
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 2'd0, 4'hF);
        vectors++;
        if (out_valid !== 4'b0000 || empty !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_all: got valid=%b empty=%b full=%b want valid=0000 empty=1 full=0",
                     out_valid, empty, full);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut_lane(i) !== m_data[i]) begin
                miscompares++;
                $display("FAIL ack_hold_data%0d: got %h want %h", i, dut_lane(i), m_data[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive_cycle(1'b0, 1'b1, 8'h3C, 2'd1, 4'h0);
        drive_cycle(1'b1, 1'b1, 8'hC3, 2'd1, 4'h0);
        vectors++;
        if (out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_prio_valid: got %b want 0000", out_valid);
        end
        vectors++;
        if (out_data1 !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_prio_data1: got %h want 00", out_data1);
        end
    endtask

`ifdef DEMUX4_AUTO_ROTATE_EN
    task automatic test_rotate();
        drive_cycle(1'b1, 1'b0, 8'h00, 2'd0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b0, 1'b1, 8'(k + 1), 2'd2, 4'hF);
            vectors++;
            if (out_valid !== 4'(1 << (k % 4)) || dut_lane(k % 4) !== 8'(k + 1)) begin
                miscompares++;
                $display("FAIL rotate_word%0d: got valid=%b data=%h want valid=%b data=%h",
                         k + 1, out_valid, dut_lane(k % 4), 4'(1 << (k % 4)), 8'(k + 1));
            end
        end
        // Next lane is 1 (still idle); fill 1,2,3, then lane 0 still holds word 05 -> stall.
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b1, 8'(8'h10 + k), 2'd0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 1'b1, 8'hEE, 2'd1, 4'h0);
            vectors++;
            if (rdy_act !== 1'b0 || out_data0 !== 8'h05) begin
                miscompares++;
                $display("FAIL rotate_stall: got ready=%b data0=%h want ready=0 data0=05",
                         rdy_act, out_data0);
            end
        end
        drive_cycle(1'b0, 1'b1, 8'hEE, 2'd1, 4'b0001);
        vectors++;
        if (out_valid !== 4'hF || out_data0 !== 8'hEE) begin
            miscompares++;
            $display("FAIL rotate_resume: got valid=%b data0=%h want valid=1111 data0=ee",
                     out_valid, out_data0);
        end
    endtask
`endif

    task automatic test_random();
        logic         pend = 1'b0;
        logic [W-1:0] d;
        logic [1:0]   c;
        logic         iv;
        logic [3:0]   ack;
        drive_cycle(1'b1, 1'b0, 8'h00, 2'd0, 4'h0);
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                d  = 8'($urandom_range(0, 255));
                c  = 2'($urandom_range(0, 3));
                iv = ($urandom_range(0, 3) != 0);
            end
            ack = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            drive_cycle(($urandom_range(0, 99) == 0), iv, d, c, ack);
            pend = iv && !rdy_exp && !reset;
            vectors++;
            if (rdy_act !== rdy_exp) begin
                miscompares++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", n, rdy_act, rdy_exp);
            end
            vectors++;
            if (out_valid !== model_vec() || full !== (model_vec() == 4'hF) ||
                empty !== (model_vec() == 4'h0)) begin
                miscompares++;
                $display("FAIL rand_valid[%0d]: got valid=%b full=%b empty=%b want valid=%b",
                         n, out_valid, full, empty, model_vec());
            end
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (dut_lane(i) !== m_data[i]) begin
                    miscompares++;
                    $display("FAIL rand_data%0d[%0d]: got %h want %h", i, n, dut_lane(i), m_data[i]);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        control  = 2'd0;
        out_ack  = 4'h0;
        m_ptr    = 0;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_data[i]  = '0;
        end
        @(posedge clock);
        #1;
        test_reset();
        test_single_lane();
        test_full_passthrough();
        test_ack_all();
        test_reset_priority();
`ifdef DEMUX4_AUTO_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
